// File: rtl/display_arbiter.sv
// Round-robin arbiter sharing one 8-digit seven-segment display among 4 sources,
// with a minimum dwell time per owner and optional preemption by source 0.
module display_arbiter #(
  parameter int          DWELL_CYCLES = 100_000_000,
  parameter logic [31:0] IDLE_DIGITS  = 32'h0000_0000,
  parameter bit          PREEMPT0     = 1'b1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [3:0]                      req,
  input  logic [127:0]                    req_digits,
  output logic [3:0]                      grant,
  output logic [31:0]                     digits,
  output logic                            switch_pulse,
  output logic [$clog2(DWELL_CYCLES)-1:0] dwell_left
);

  localparam int            DW     = $clog2(DWELL_CYCLES);
  localparam logic [DW-1:0] RELOAD = DW'(DWELL_CYCLES - 1);
  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_OWN  = 1'b1;

  logic [0:0]    state, nxt_state;
  logic [1:0]    owner, nxt_owner;
  logic [1:0]    last_owner, nxt_last;
  logic [DW-1:0] nxt_dwell;
  logic          nxt_pulse;
  logic [3:0]    others;
  logic [3:0]    cand;
  logic          pick_vld;
  logic [1:0]    pick_idx;

  // Returns {found, index} for the first set candidate after base, wrapping mod 4.
  function automatic logic [2:0] rr_pick(input logic [3:0] c, input logic [1:0] base);
    logic       found;
    logic [1:0] idx;
    logic [1:0] win;
    found = 1'b0;
    win   = 2'd0;
    for (int i = 1; i <= 4; i++) begin
      idx = base + 2'(i);
      if (c[idx] && !found) begin
        found = 1'b1;
        win   = idx;
      end
    end
    return {found, win};
  endfunction

  always_comb begin
    others = req & ~(4'b0001 << owner);
    // The current owner never competes against itself for a switch.
    cand   = (state == ST_OWN) ? others : req;
    {pick_vld, pick_idx} = rr_pick(cand, last_owner);

    nxt_state = state;
    nxt_owner = owner;
    nxt_last  = last_owner;
    nxt_dwell = dwell_left;
    nxt_pulse = 1'b0;

    case (state)
      ST_IDLE: begin
        if (pick_vld) begin
          nxt_state = ST_OWN;
          nxt_owner = pick_idx;
          nxt_dwell = RELOAD;
          nxt_pulse = 1'b1;
        end else begin
          nxt_dwell = '0;
        end
      end
      default: begin
        if (!req[owner]) begin
          nxt_last  = owner;
          nxt_pulse = 1'b1;
          if (pick_vld) begin
            nxt_owner = pick_idx;
            nxt_dwell = RELOAD;
          end else begin
            nxt_state = ST_IDLE;
            nxt_dwell = '0;
          end
        end else if (PREEMPT0 && (owner != 2'd0) && req[0]) begin
          // Remember the interrupted owner so rotation resumes around it.
          nxt_last  = owner;
          nxt_owner = 2'd0;
          nxt_dwell = RELOAD;
          nxt_pulse = 1'b1;
        end else if ((dwell_left == '0) && pick_vld) begin
          nxt_last  = owner;
          nxt_owner = pick_idx;
          nxt_dwell = RELOAD;
          nxt_pulse = 1'b1;
        end else if (dwell_left == '0) begin
          nxt_dwell = RELOAD;
        end else begin
          nxt_dwell = dwell_left - 1'b1;
        end
      end
    endcase
  end

  // Registered outputs: all follow the next-owner decision on the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      owner        <= 2'd0;
      last_owner   <= 2'd3;
      dwell_left   <= '0;
      switch_pulse <= 1'b0;
      grant        <= 4'b0000;
      digits       <= IDLE_DIGITS;
    end else begin
      state        <= nxt_state;
      owner        <= nxt_owner;
      last_owner   <= nxt_last;
      dwell_left   <= nxt_dwell;
      switch_pulse <= nxt_pulse;
      if (nxt_state == ST_OWN) begin
        grant  <= 4'b0001 << nxt_owner;
        digits <= req_digits[32*int'(nxt_owner) +: 32];
      end else begin
        grant  <= 4'b0000;
        digits <= IDLE_DIGITS;
      end
    end
  end

endmodule

// File: tb/tb_display_arbiter.sv
// Directed scoreboard bench for display_arbiter with DWELL_CYCLES = 4 and PREEMPT0 = 1.
module tb_display_arbiter;

  logic         clk;
  logic         rst;
  logic [3:0]   req;
  logic [127:0] req_digits;
  logic [3:0]   grant;
  logic [31:0]  digits;
  logic         switch_pulse;
  logic [1:0]   dwell_left;

  logic [31:0] s0, s1, s2, s3;
  assign req_digits = {s3, s2, s1, s0};

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  g;
    logic [31:0] d;
    logic        p;
    logic [1:0]  dw;
    string       tag;
  } exp_t;

  exp_t sb[$];

  display_arbiter #(
    .DWELL_CYCLES(4),
    .IDLE_DIGITS (32'h0000_0000),
    .PREEMPT0    (1'b1)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_digits  (req_digits),
    .grant       (grant),
    .digits      (digits),
    .switch_pulse(switch_pulse),
    .dwell_left  (dwell_left)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc(input logic [3:0] g, input logic [31:0] d, input logic p,
                     input logic [1:0] dw, input string tag);
    exp_t e;
    e.g = g; e.d = d; e.p = p; e.dw = dw; e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    checks++;
    assert (sb.size() > 0) else begin
      failures++;
      $error("FAIL %s scoreboard empty", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (grant === e.g) else begin
        failures++;
        $error("FAIL %s grant got=%b exp=%b", e.tag, grant, e.g);
      end
      checks++;
      assert (digits === e.d) else begin
        failures++;
        $error("FAIL %s digits got=%h exp=%h", e.tag, digits, e.d);
      end
      checks++;
      assert (switch_pulse === e.p) else begin
        failures++;
        $error("FAIL %s switch_pulse got=%b exp=%b", e.tag, switch_pulse, e.p);
      end
      checks++;
      assert (dwell_left === e.dw) else begin
        failures++;
        $error("FAIL %s dwell_left got=%0d exp=%0d", e.tag, dwell_left, e.dw);
      end
      checks++;
      assert ($countones(grant) <= 1) else begin
        failures++;
        $error("FAIL %s onehot grant got=%b exp=onehot_or_zero", e.tag, grant);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    req = 4'b0000;
    s0 = 32'hA0A0_A0A0;
    s1 = 32'h1234_5678;
    s2 = 32'h2222_2222;
    s3 = 32'h3333_3333;

    // Reset and idle
    cyc(4'b0000, 32'h0, 1'b0, 2'd0, "rst");
    cyc(4'b0000, 32'h0, 1'b0, 2'd0, "rst");
    #1 rst = 1'b0;
    for (int i = 0; i < 10; i++) cyc(4'b0000, 32'h0, 1'b0, 2'd0, "idle");

    // Single requester, live data
    req = 4'b0010;
    cyc(4'b0010, 32'h1234_5678, 1'b1, 2'd3, "grant1");
    s1 = 32'hCAFE_0001;
    cyc(4'b0010, 32'hCAFE_0001, 1'b0, 2'd2, "live1");
    req = 4'b0000;
    cyc(4'b0000, 32'h0, 1'b1, 2'd0, "rel_idle");

    // Restart rotation from a fresh reset
    rst = 1'b1;
    cyc(4'b0000, 32'h0, 1'b0, 2'd0, "rst2");
    rst = 1'b0;
    s1 = 32'h1111_1111;

    // Rotation between owners 1 and 2
    req = 4'b0110;
    cyc(4'b0010, s1, 1'b1, 2'd3, "rr1");
    cyc(4'b0010, s1, 1'b0, 2'd2, "rr1");
    cyc(4'b0010, s1, 1'b0, 2'd1, "rr1");
    cyc(4'b0010, s1, 1'b0, 2'd0, "rr1");
    cyc(4'b0100, s2, 1'b1, 2'd3, "rr2");
    cyc(4'b0100, s2, 1'b0, 2'd2, "rr2");
    cyc(4'b0100, s2, 1'b0, 2'd1, "rr2");
    cyc(4'b0100, s2, 1'b0, 2'd0, "rr2");
    cyc(4'b0010, s1, 1'b1, 2'd3, "rr1b");

    // Owner 1 releases, owner 2 takes over, then preemption by 0
    req = 4'b0100;
    cyc(4'b0100, s2, 1'b1, 2'd3, "rel_to2");
    req = 4'b0101;
    cyc(4'b0001, s0, 1'b1, 2'd3, "preempt0");
    req = 4'b0100;
    cyc(4'b0100, s2, 1'b1, 2'd3, "resume2");

    // Owner 3 alone, then back to idle
    req = 4'b1000;
    cyc(4'b1000, s3, 1'b1, 2'd3, "to3");
    req = 4'b0000;
    cyc(4'b0000, 32'h0, 1'b1, 2'd0, "3_idle");
    cyc(4'b0000, 32'h0, 1'b0, 2'd0, "idle_hold");

    // Lone req[3] held: only the first edge pulses, dwell wraps
    req = 4'b1000;
    cyc(4'b1000, s3, 1'b1, 2'd3, "lone3");
    for (int i = 0; i < 20; i++) begin
      logic [1:0] dwexp;
      dwexp = 2'(3 - ((i + 1) % 4));
      cyc(4'b1000, s3, 1'b0, dwexp, "lone3_hold");
    end

    // Switch to owner 1, reset mid-dwell, restart at 0-first rotation
    req = 4'b0010;
    cyc(4'b0010, s1, 1'b1, 2'd3, "to1");
    cyc(4'b0010, s1, 1'b0, 2'd2, "to1_dw2");
    rst = 1'b1;
    cyc(4'b0000, 32'h0, 1'b0, 2'd0, "rst_mid");
    rst = 1'b0;
    cyc(4'b0010, s1, 1'b1, 2'd3, "after_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
